// File: rtl/bg_pkg.sv
// Shared constants and pipeline tag type for the background ROM arbiter
// and the sprite fetch logic that reuses coord_to_addr.
package bg_pkg;

    localparam int unsigned H_RES   = 800;
    localparam int unsigned V_RES   = 600;
    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned RGB_W   = 12;
    localparam int unsigned COORD_W = 10;

    // Source of a ROM access; selects which output port gets the data.
    typedef enum logic {
        SRC_VID = 1'b0,
        SRC_QRY = 1'b1
    } src_t;

    // Tag travelling alongside each access through the read pipeline.
    typedef struct packed {
        logic valid;
        src_t src;
        logic oob;
    } tag_t;

    localparam int unsigned TAG_W = $bits(tag_t);

endpackage

// File: rtl/coord_to_addr.sv
// Combinational (x, y) to linear ROM address conversion with range check.
// Uses y*800 = y*512 + y*256 + y*32 so no multiplier is inferred.
module coord_to_addr
    import bg_pkg::*;
(
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               in_range
);

    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] x_ext;

    // Shift-add address and bounds test; addr is only meaningful when in_range.
    always_comb begin
        y_ext    = ADDR_W'(y);
        x_ext    = ADDR_W'(x);
        addr     = (y_ext << 9) + (y_ext << 8) + (y_ext << 5) + x_ext;
        in_range = (x < COORD_W'(H_RES)) && (y < COORD_W'(V_RES));
    end

endmodule

// File: rtl/bg_rom_arbiter.sv
// Shares the single-port background ROM between VGA scanout (strict
// priority) and collision queries (served in idle cycles). Each access is
// tagged with its source and returned with a fixed two-cycle latency.
module bg_rom_arbiter
    import bg_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,

    input  logic                vid_req,
    input  logic [COORD_W-1:0]  vid_x,
    input  logic [COORD_W-1:0]  vid_y,
    output logic                vid_valid,
    output logic [RGB_W-1:0]    vid_rgb,

    input  logic                q_valid,
    output logic                q_ready,
    input  logic [COORD_W-1:0]  q_x,
    input  logic [COORD_W-1:0]  q_y,
    output logic                q_rvalid,
    output logic [RGB_W-1:0]    q_rdata,
    output logic                q_oob,

    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [RGB_W-1:0]    rom_data
);

    logic                q_busy;
    logic                q_accept;
    logic [COORD_W-1:0]  sel_x;
    logic [COORD_W-1:0]  sel_y;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_in_range;
    tag_t                issue_tag;

    // Tags: tag_s1 sits beside rom_addr, tag_s2 lines up with the ROM's
    // registered douta, tag_out qualifies the output registers.
    tag_t                tag_s1;
    tag_t                tag_s2;
    tag_t                tag_out;

    // Arbitration: video always wins; a query issues only when video is idle.
    always_comb begin
        q_ready         = rst_n && !vid_req && !q_busy;
        q_accept        = q_valid && q_ready;
        issue_tag       = '0;
        issue_tag.valid = vid_req || q_accept;
        if (vid_req) begin
            sel_x         = vid_x;
            sel_y         = vid_y;
            issue_tag.src = SRC_VID;
        end else begin
            sel_x         = q_x;
            sel_y         = q_y;
            issue_tag.src = SRC_QRY;
        end
        issue_tag.oob = !sel_in_range;
    end

    coord_to_addr u_coord_to_addr (
        .x        (sel_x),
        .y        (sel_y),
        .addr     (sel_addr),
        .in_range (sel_in_range)
    );

    // Stage 1: register the ROM address; out-of-range accesses leave it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr <= '0;
            tag_s1   <= '0;
        end else begin
            tag_s1 <= issue_tag;
            if (issue_tag.valid && sel_in_range) begin
                rom_addr <= sel_addr;
            end
        end
    end

    // Delay the tag while the ROM performs its one-cycle synchronous read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_s2 <= '0;
        end else begin
            tag_s2 <= tag_s1;
        end
    end

    // Stage 2: capture ROM data (zero for out-of-range) into the port selected by the tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_out <= '0;
            vid_rgb <= '0;
            q_rdata <= '0;
            q_oob   <= 1'b0;
        end else begin
            tag_out <= tag_s2;
            if (tag_s2.valid) begin
                if (tag_s2.src == SRC_VID) begin
                    vid_rgb <= tag_s2.oob ? '0 : rom_data;
                end else begin
                    q_rdata <= tag_s2.oob ? '0 : rom_data;
                    q_oob   <= tag_s2.oob;
                end
            end
        end
    end

    // Valid strobes decoded from the output tag; only one port pulses per cycle.
    always_comb begin
        vid_valid = tag_out.valid && (tag_out.src == SRC_VID);
        q_rvalid  = tag_out.valid && (tag_out.src == SRC_QRY);
    end

    // Single outstanding query: busy from accept until the response cycle ends.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_busy <= 1'b0;
        end else if (q_accept) begin
            q_busy <= 1'b1;
        end else if (q_rvalid) begin
            q_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bg_rom_arbiter.sv
// Self-checking bench for bg_rom_arbiter with a behavioural ROM model.
module tb_bg_rom_arbiter;

    logic        clk;
    logic        rst_n;
    logic        vid_req;
    logic [9:0]  vid_x;
    logic [9:0]  vid_y;
    logic        vid_valid;
    logic [11:0] vid_rgb;
    logic        q_valid;
    logic        q_ready;
    logic [9:0]  q_x;
    logic [9:0]  q_y;
    logic        q_rvalid;
    logic [11:0] q_rdata;
    logic        q_oob;
    logic [18:0] rom_addr;
    logic [11:0] rom_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        bit          is_q;
        logic [11:0] data;
        bit          oob;
    } resp_t;

    bg_rom_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vid_req   (vid_req),
        .vid_x     (vid_x),
        .vid_y     (vid_y),
        .vid_valid (vid_valid),
        .vid_rgb   (vid_rgb),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .q_x       (q_x),
        .q_y       (q_y),
        .q_rvalid  (q_rvalid),
        .q_rdata   (q_rdata),
        .q_oob     (q_oob),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Content of background ROM word a (arbitrary but address-dependent).
    function automatic logic [11:0] rom_word(input logic [18:0] a);
        return a[11:0] ^ {a[18:12], a[4:0]} ^ 12'h5A3;
    endfunction

    // Expected pixel for a coordinate: ROM word y*800+x, or 0 off-screen.
    function automatic logic [11:0] exp_pix(input int x, input int y);
        if (x < 800 && y < 600) return rom_word(19'(y * 800 + x));
        return 12'h000;
    endfunction

    // Synchronous single-port ROM, one-cycle read.
    initial rom_data = '0;
    always @(posedge clk) rom_data <= rom_word(rom_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        vid_req = 1'b0;
        q_valid = 1'b0;
        vid_x   = '0;
        vid_y   = '0;
        q_x     = '0;
        q_y     = '0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        vid_req = 1'b0;
        q_valid = 1'b1;
        vid_x   = 10'($urandom_range(0, 799));
        vid_y   = 10'($urandom_range(0, 599));
        q_x     = 10'($urandom_range(0, 799));
        q_y     = 10'($urandom_range(0, 599));
        step();
        step();
        checks++; if (rom_addr !== 19'd0) begin errors++; $display("FAIL reset_rom_addr got %0d expected 0", rom_addr); end
        checks++; if (vid_valid !== 1'b0) begin errors++; $display("FAIL reset_vid_valid got %0b expected 0", vid_valid); end
        checks++; if (vid_rgb !== 12'h000) begin errors++; $display("FAIL reset_vid_rgb got %0h expected 0", vid_rgb); end
        checks++; if (q_rvalid !== 1'b0) begin errors++; $display("FAIL reset_q_rvalid got %0b expected 0", q_rvalid); end
        checks++; if (q_rdata !== 12'h000) begin errors++; $display("FAIL reset_q_rdata got %0h expected 0", q_rdata); end
        checks++; if (q_oob !== 1'b0) begin errors++; $display("FAIL reset_q_oob got %0b expected 0", q_oob); end
        checks++; if (q_ready !== 1'b0) begin errors++; $display("FAIL reset_q_ready got %0b expected 0", q_ready); end
        drive_idle();
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_video_fetch();
        vid_req = 1'b1;
        vid_x   = 10'd5;
        vid_y   = 10'd2;
        step();
        checks++; if (rom_addr !== 19'd1605) begin errors++; $display("FAIL vid_rom_addr got %0d expected 1605", rom_addr); end
        checks++; if (vid_valid !== 1'b0) begin errors++; $display("FAIL vid_early_e0 got %0b expected 0", vid_valid); end
        drive_idle();
        step();
        checks++; if (vid_valid !== 1'b0) begin errors++; $display("FAIL vid_early_e1 got %0b expected 0", vid_valid); end
        step();
        checks++; if (vid_valid !== 1'b1) begin errors++; $display("FAIL vid_valid_e2 got %0b expected 1", vid_valid); end
        checks++; if (vid_rgb !== rom_word(19'd1605)) begin errors++; $display("FAIL vid_rgb got %0h expected %0h", vid_rgb, rom_word(19'd1605)); end
        checks++; if (q_rvalid !== 1'b0) begin errors++; $display("FAIL vid_q_rvalid got %0b expected 0", q_rvalid); end
        step();
        checks++; if (vid_valid !== 1'b0) begin errors++; $display("FAIL vid_single_pulse got %0b expected 0", vid_valid); end
    endtask

    task automatic test_query_corner();
        q_valid = 1'b1;
        q_x     = 10'd799;
        q_y     = 10'd599;
        #1;
        checks++; if (q_ready !== 1'b1) begin errors++; $display("FAIL qc_ready_idle got %0b expected 1", q_ready); end
        step();
        checks++; if (rom_addr !== 19'd479999) begin errors++; $display("FAIL qc_rom_addr got %0d expected 479999", rom_addr); end
        drive_idle();
        #1;
        checks++; if (q_ready !== 1'b0) begin errors++; $display("FAIL qc_ready_busy0 got %0b expected 0", q_ready); end
        step();
        checks++; if (q_rvalid !== 1'b0) begin errors++; $display("FAIL qc_rvalid_early got %0b expected 0", q_rvalid); end
        checks++; if (q_ready !== 1'b0) begin errors++; $display("FAIL qc_ready_busy1 got %0b expected 0", q_ready); end
        step();
        checks++; if (q_rvalid !== 1'b1) begin errors++; $display("FAIL qc_rvalid got %0b expected 1", q_rvalid); end
        checks++; if (q_oob !== 1'b0) begin errors++; $display("FAIL qc_oob got %0b expected 0", q_oob); end
        checks++; if (q_rdata !== rom_word(19'd479999)) begin errors++; $display("FAIL qc_rdata got %0h expected %0h", q_rdata, rom_word(19'd479999)); end
        checks++; if (q_ready !== 1'b0) begin errors++; $display("FAIL qc_ready_resp got %0b expected 0", q_ready); end
        checks++; if (vid_valid !== 1'b0) begin errors++; $display("FAIL qc_vid_valid got %0b expected 0", vid_valid); end
        step();
        checks++; if (q_rvalid !== 1'b0) begin errors++; $display("FAIL qc_rvalid_pulse got %0b expected 0", q_rvalid); end
        checks++; if (q_ready !== 1'b1) begin errors++; $display("FAIL qc_ready_free got %0b expected 1", q_ready); end
    endtask

    task automatic test_query_oob();
        q_valid = 1'b1;
        q_x     = 10'd800;
        q_y     = 10'd10;
        #1;
        checks++; if (q_ready !== 1'b1) begin errors++; $display("FAIL qo_ready got %0b expected 1", q_ready); end
        step();
        drive_idle();
        checks++; if (rom_addr !== 19'd479999) begin errors++; $display("FAIL qo_rom_addr_held got %0d expected 479999", rom_addr); end
        step();
        step();
        checks++; if (q_rvalid !== 1'b1) begin errors++; $display("FAIL qo_rvalid got %0b expected 1", q_rvalid); end
        checks++; if (q_rdata !== 12'h000) begin errors++; $display("FAIL qo_rdata got %0h expected 0", q_rdata); end
        checks++; if (q_oob !== 1'b1) begin errors++; $display("FAIL qo_oob got %0b expected 1", q_oob); end
        step();
    endtask

    // mode 0: video+query together for 3 cycles then video idle;
    // mode 1: video every other cycle with continuous queries; mode 2: random mix.
    task automatic test_traffic(input int mode, input int ncyc);
        resp_t       pend[$];
        resp_t       r;
        int          now       = 0;
        int          q_free_at = 0;
        int          nvid_got  = 0;
        bit          q_hold    = 0;
        int          hx        = 0;
        int          hy        = 0;
        logic [18:0] exp_addr  = '0;

        drive_idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < ncyc + 4; c++) begin
            bit vr;
            bit active;
            bit exp_ready;
            bit have;
            int vx;
            int vy;
            active = (c < ncyc);
            case (mode)
                0:       vr = (c < 3);
                1:       vr = (c % 2 == 0);
                default: vr = ($urandom_range(0, 2) == 0);
            endcase
            vr = vr && active;
            vx = $urandom_range(0, 830);
            vy = $urandom_range(0, 630);
            if (!q_hold && active) begin
                if ((mode == 0 && c == 0) || mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) begin
                    q_hold = 1;
                    hx = $urandom_range(0, 830);
                    hy = $urandom_range(0, 630);
                end
            end
            vid_req = vr;
            vid_x   = 10'(vx);
            vid_y   = 10'(vy);
            q_valid = q_hold;
            q_x     = 10'(hx);
            q_y     = 10'(hy);
            #1;
            exp_ready = !vr && (now >= q_free_at);
            checks++; if (q_ready !== exp_ready) begin errors++; $display("FAIL tr%0d_q_ready c=%0d got %0b expected %0b", mode, c, q_ready, exp_ready); end
            if (vr) begin
                pend.push_back('{due: now + 3, is_q: 0, data: exp_pix(vx, vy), oob: !(vx < 800 && vy < 600)});
                if (vx < 800 && vy < 600) exp_addr = 19'(vy * 800 + vx);
            end else if (q_hold && exp_ready) begin
                pend.push_back('{due: now + 3, is_q: 1, data: exp_pix(hx, hy), oob: !(hx < 800 && hy < 600)});
                if (hx < 800 && hy < 600) exp_addr = 19'(hy * 800 + hx);
                q_free_at = now + 4;
                q_hold    = 0;
            end
            step();
            now++;
            checks++; if (rom_addr !== exp_addr) begin errors++; $display("FAIL tr%0d_rom_addr c=%0d got %0d expected %0d", mode, c, rom_addr, exp_addr); end
            have = 0;
            r    = '{due: 0, is_q: 0, data: '0, oob: 0};
            if (pend.size() > 0 && pend[0].due == now) begin
                r    = pend.pop_front();
                have = 1;
            end
            if (vid_valid === 1'b1) nvid_got++;
            checks++; if (vid_valid !== (have && !r.is_q)) begin errors++; $display("FAIL tr%0d_vid_valid c=%0d got %0b expected %0b", mode, c, vid_valid, have && !r.is_q); end
            checks++; if (q_rvalid !== (have && r.is_q)) begin errors++; $display("FAIL tr%0d_q_rvalid c=%0d got %0b expected %0b", mode, c, q_rvalid, have && r.is_q); end
            if (have && !r.is_q) begin
                checks++; if (vid_rgb !== r.data) begin errors++; $display("FAIL tr%0d_vid_rgb c=%0d got %0h expected %0h", mode, c, vid_rgb, r.data); end
            end
            if (have && r.is_q) begin
                checks++; if (q_rdata !== r.data) begin errors++; $display("FAIL tr%0d_q_rdata c=%0d got %0h expected %0h", mode, c, q_rdata, r.data); end
                checks++; if (q_oob !== r.oob) begin errors++; $display("FAIL tr%0d_q_oob c=%0d got %0b expected %0b", mode, c, q_oob, r.oob); end
            end
        end
        checks++; if (pend.size() != 0) begin errors++; $display("FAIL tr%0d_drain got %0d pending expected 0", mode, pend.size()); end
        if (mode == 0) begin
            checks++; if (nvid_got != 3) begin errors++; $display("FAIL tr0_vid_count got %0d expected 3", nvid_got); end
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        drive_idle();
        step();
        step();
        vid_req = 1'b1;
        vid_x   = 10'd5;
        vid_y   = 10'd2;
        step();
        drive_idle();
        q_valid = 1'b1;
        q_x     = 10'd3;
        q_y     = 10'd4;
        #1;
        checks++; if (q_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_pre got %0b expected 1", q_ready); end
        step();
        drive_idle();
        rst_n = 1'b0;
        #1;
        checks++; if (q_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_in_reset got %0b expected 0", q_ready); end
        step();
        checks++; if (rom_addr !== 19'd0) begin errors++; $display("FAIL rm_rom_addr got %0d expected 0", rom_addr); end
        checks++; if (vid_valid !== 1'b0 || q_rvalid !== 1'b0) begin errors++; $display("FAIL rm_valids got %0b%0b expected 00", vid_valid, q_rvalid); end
        checks++; if (vid_rgb !== 12'h000 || q_rdata !== 12'h000 || q_oob !== 1'b0) begin errors++; $display("FAIL rm_data got %0h %0h %0b expected 0 0 0", vid_rgb, q_rdata, q_oob); end
        rst_n   = 1'b1;
        q_valid = 1'b1;
        q_x     = 10'd7;
        q_y     = 10'd1;
        #1;
        checks++; if (q_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_release got %0b expected 1", q_ready); end
        step();
        drive_idle();
        checks++; if (rom_addr !== 19'd807) begin errors++; $display("FAIL rm_new_addr got %0d expected 807", rom_addr); end
        checks++; if (vid_valid !== 1'b0 || q_rvalid !== 1'b0) begin errors++; $display("FAIL rm_late_pulse0 got %0b%0b expected 00", vid_valid, q_rvalid); end
        step();
        checks++; if (vid_valid !== 1'b0 || q_rvalid !== 1'b0) begin errors++; $display("FAIL rm_late_pulse1 got %0b%0b expected 00", vid_valid, q_rvalid); end
        step();
        checks++; if (q_rvalid !== 1'b1) begin errors++; $display("FAIL rm_new_rvalid got %0b expected 1", q_rvalid); end
        checks++; if (q_rdata !== rom_word(19'd807)) begin errors++; $display("FAIL rm_new_rdata got %0h expected %0h", q_rdata, rom_word(19'd807)); end
        checks++; if (vid_valid !== 1'b0) begin errors++; $display("FAIL rm_vid_after got %0b expected 0", vid_valid); end
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_video_fetch();
        test_query_corner();
        test_query_oob();
        test_traffic(0, 8);
        test_traffic(1, 60);
        test_traffic(2, 400);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bg_rom_arbiter.md
# bg_rom_arbiter

Shares the single-port 800x600 background ROM (12-bit RGB, 19-bit address, one-cycle synchronous read) between two requesters. The VGA scanout path has strict priority, and the game-logic collision-query path is served in free cycles. It sits between the `background` ROM instance and both the display pipeline and the player/wall collision logic. It converts (x, y) coordinates to linear addresses, tags each access by source, and routes the returned data back with fixed latency.

## Interface
- `H_RES`, 800, horizontal pixels; address stride.
- `V_RES`, 600, vertical lines.
- `ADDR_W`, 19, ROM address width.
- `RGB_W`, 12, ROM data width, {r,g,b} 4 bits each.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `vid_req`  in  1  scanout pixel fetch request, sampled every cycle.
- `vid_x`  in  10  scanout column.
- `vid_y`  in  10  scanout row.
- `vid_valid`  out  1  scanout data valid.
- `vid_rgb`  out  12  scanout pixel.
- `q_valid`  in  1  query request valid.
- `q_ready`  out  1  query accepted when `q_valid && q_ready`.
- `q_x`  in  10  query column.
- `q_y`  in  10  query row.
- `q_rvalid`  out  1  query response valid, one-cycle pulse.
- `q_rdata`  out  12  query pixel.
- `q_oob`  out  1  query coordinate out of range; valid with `q_rvalid`.
- `rom_addr`  out  19  to ROM `addra`; registered.
- `rom_data`  in  12  from ROM `douta`.

## Operation
- Address: `addr = y*H_RES + x`.
  - Computed with shift-add (y<<9 + y<<8 + y<<5 + x); no multiplier.
  - Max in-range value 479999.
- In-range test: `x < H_RES && y < V_RES`.
  - Out-of-range accesses do not change `rom_addr`.
  - They flow through the pipeline with forced data 0.
- Grant: video wins any cycle `vid_req`=1. A query is granted only when `vid_req`=0.
- `q_ready` = `!vid_req && !q_busy`. This is a combinational path from `vid_req`; it is intentional.
- `q_busy`:
  - Set on query accept.
  - Cleared the cycle `q_rvalid` is asserted.
  - At most one query is outstanding.
- `q_x`/`q_y` need only be stable during the accept cycle.
- Video has no backpressure; every `vid_req` produces exactly one `vid_valid`.
- Video requests on consecutive cycles are legal. Queries wait indefinitely until a gap; there is no starvation guard.
- Pipeline tag per stage: {valid, src(VID/QRY), oob}.
  - Stage 1: `rom_addr` register plus tag.
  - Stage 2: output register capturing `rom_data` (or 0 if oob) plus tag.
- Outputs are routed by tag:
  - VID sets `vid_valid` and `vid_rgb`.
  - QRY sets `q_rvalid`, `q_rdata` and `q_oob`.
  - The non-selected output's valid stays 0. Data holds its last value.

## Timing
- Request sampled at edge N.
  - `rom_addr` updates at edge N.
  - ROM data is available after edge N+1.
  - `vid_valid`/`q_rvalid` are high in the cycle after edge N+2.
  - Latency is fixed at 2 cycles for both sources, in range or not.
- Full throughput is one access per cycle; back-to-back video yields back-to-back `vid_valid`.
- A video request and a query in the same cycle: video is issued and the query stays pending with `q_ready`=0. The query issues in the first cycle with `vid_req`=0.
- Query accepted at N: `q_ready`=0 from N+1 through the `q_rvalid` cycle, then may rise in the next cycle.
- Reset (`rst_n`=0 at an edge) sets all of the following to 0, and `q_ready` is 0 while in reset:
  - `rom_addr`, `vid_valid`, `vid_rgb`, `q_rvalid`, `q_rdata`, `q_oob`, `q_busy`, all tags.
- Reset mid-operation: in-flight accesses are dropped with no late valid pulses. The first request after reset is accepted on the first edge with `rst_n`=1.

## Structure
- Shared package `bg_pkg`:
  - `H_RES`, `V_RES`, `ADDR_W`, `RGB_W`.
  - Source tag constants `SRC_VID`=0, `SRC_QRY`=1.
  - Pipeline tag struct/width.
- Sub-module `coord_to_addr`: combinational shift-add address computation plus range check. It is reused by the sprite fetch logic.
- The ROM stays outside this block; the top level wires `rom_addr`/`rom_data` to `background`.

## Test plan
- Video fetch (5,2) at cycle 10:
  - `rom_addr`=1605 after edge 10.
  - `vid_valid`=1 with ROM word 1605 after edge 12.
  - `q_rvalid` stays 0.
- Query (799,599) with no video:
  - Accepted immediately; `rom_addr`=479999.
  - `q_rvalid`=1, `q_oob`=0 two cycles later.
  - `q_ready`=0 between accept and response.
- Query (800,10):
  - `q_rvalid` after 2 cycles with `q_rdata`=0, `q_oob`=1.
  - `rom_addr` unchanged.
- Simultaneous `vid_req` and `q_valid` for 3 cycles, then `vid_req` low:
  - 3 `vid_valid` pulses back-to-back.
  - Query accepted in cycle 4; `q_rvalid` in cycle 6.
- Alternating video requests (every other cycle) with continuous `q_valid`: queries are accepted only in gaps, each response is correct, and no video response is lost or delayed.
- `rst_n` low for 1 cycle with one video and one query in flight: no `vid_valid`/`q_rvalid` afterwards, all outputs 0, and a new query is accepted on the first cycle after release.
